binary_to_bcd_stream: RTL
=========================

Name: binary_to_bcd_stream

Overview:
Sequential double-dabble converter from a binary word to packed BCD, with valid/ready handshakes on both sides. It generalises the free-running transcoder with:
- optional two's-complement input (sign/magnitude output);
- a configurable number of shift steps per clock;
- a significant-digit count for display blanking.
It sits between numeric datapaths and display or UART text formatters.

Parameters:
WIDTH, 16, input word width; legal range 2..31.
SIGNED, 0, 1 = in_data is two's complement; 0 = unsigned.
BITS_PER_CYCLE, 1, double-dabble steps per clock; legal range 1..WIDTH.
DIGITS (localparam), computed, decimal digits of the maximum magnitude. Maximum magnitude is 2^WIDTH-1 when unsigned and 2^(WIDTH-1) when signed. Computed by a constant function; OUT_WIDTH = 4*DIGITS.
ITERS (localparam), ceil(WIDTH/BITS_PER_CYCLE).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
in_valid  in  1  in_data is valid.
in_ready  out  1  converter can accept a word.
in_data  in  WIDTH  binary operand.
out_valid  out  1  result is valid.
out_ready  in  1  consumer accepts the result.
out_bcd  out  OUT_WIDTH  packed BCD, digit 0 in bits [3:0].
out_negative  out  1  operand was negative; always 0 when SIGNED=0.
out_digits  out  clog2(DIGITS+1)  count of significant digits, 1..DIGITS.

Behaviour:
- Reset (asserted): state=IDLE, in_ready=1, out_valid=0, out_bcd=0, out_negative=0, out_digits=1, internal shift register and counter cleared. Reset asserted mid-conversion or while holding a result discards all work immediately.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready at a rising edge:
    - capture magnitude: in_data if unsigned or non-negative; two's-complement negation otherwise.
    - latch the sign; -2^(WIDTH-1) yields magnitude 2^(WIDTH-1) with no overflow.
    - load the step counter with ITERS; go to SHIFT.
  - in_data is sampled only at the handshake edge.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each clock performs BITS_PER_CYCLE steps. One step: add 3 to every BCD digit ≥5, then shift left one bit, MSB of magnitude first.
  - The magnitude is zero-extended at the top to ITERS*BITS_PER_CYCLE bits; extra leading zero steps do not change the result.
  - When the counter reaches its last iteration, go to DONE.
- Latency: out_valid rises exactly ITERS clocks after the accept edge (WIDTH=16, B=1: 16 clocks).
- DONE:
  - out_valid=1.
  - out_bcd, out_negative and out_digits are registered and held stable until out_valid && out_ready.
  - On that handshake go to IDLE.
  - in_ready stays 0; throughput is one word per ITERS+2 clocks worst case.
  - If out_ready is already high on entry, the handshake completes in the first DONE cycle.
- out_digits: index of the most-significant non-zero digit plus 1. A zero result reports 1.
- out_bcd never contains a digit >9. Unused upper digits are 0.
- No overlap between input acceptance and output presentation.
- in_valid toggling while in_ready=0 is ignored.

Test Plan:
- WIDTH=16, SIGNED=0, B=1:
  - 12345 → out_bcd=20'h12345, out_digits=5, out_negative=0; out_valid 16 clocks after accept.
  - 0 → 20'h00000, digits=1.
  - 16'hFFFF → 20'h65535.
  - 9876 → 20'h09876, digits=4.
- SIGNED=1, WIDTH=16:
  - 16'h8000 → 20'h32768, negative=1, digits=5.
  - 16'hFFFF → 20'h00001, negative=1, digits=1.
  - 16'h7FFF → 20'h32767, negative=0.
- Backpressure: hold out_ready=0 for 10 clocks after out_valid. Outputs stay bit-stable, in_ready stays 0, and a new in_valid is ignored. Release out_ready: one handshake, then in_ready=1 the next cycle.
- BITS_PER_CYCLE=3, WIDTH=16: ITERS=6. 12345 → 20'h12345 with out_valid 6 clocks after accept. Repeat for B=16 (1 clock).
- Reset mid-SHIFT: assert reset_n=0 asynchronously between edges. Outputs return to reset values before the next edge, and no stale out_valid appears afterwards. A new conversion then completes correctly.
- Width sweep, WIDTH 2..31 both modes: DIGITS is unsigned 1 (W=2), 2 (W=4), 5 (W=16), 10 (W=31); signed 1 (W=2), 10 (W=31). Random operands compared against a $sformatf("%0d") reference model.

Source files
------------

// File: rtl/binary_to_bcd_stream.sv
// Sequential double-dabble binary to packed BCD converter, valid/ready on both sides.
// Result appears ITERS clocks after accept and is held until out_ready; no input is taken while busy.
package binary_to_bcd_stream_pkg;

  function automatic int bcd_digits(input int width, input int signed_mode);
    logic [63:0] mag;
    int          n;
    mag = (signed_mode != 0) ? (64'd1 << (width - 1)) : ((64'd1 << width) - 64'd1);
    n   = 1;
    while (mag >= 64'd10) begin
      mag = mag / 64'd10;
      n++;
    end
    return n;
  endfunction

endpackage

module binary_to_bcd_stream
  import binary_to_bcd_stream_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int SIGNED         = 0,
  parameter int BITS_PER_CYCLE = 1,
  localparam int DIGITS        = bcd_digits(WIDTH, SIGNED),
  localparam int OUT_WIDTH     = 4 * DIGITS,
  localparam int DIG_W         = $clog2(DIGITS + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_bcd,
  output logic                 out_negative,
  output logic [DIG_W-1:0]     out_digits
);

  localparam int ITERS = (WIDTH + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int PAD_W = ITERS * BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [PAD_W-1:0]     mag_q, mag_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [OUT_WIDTH-1:0] res_bcd_q, res_bcd_d;
  logic                 res_neg_q, res_neg_d;
  logic [DIG_W-1:0]     res_dig_q, res_dig_d;

  logic                 in_neg;
  logic [WIDTH-1:0]     in_mag;
  logic [OUT_WIDTH-1:0] step_acc;
  logic [PAD_W-1:0]     step_mag;
  logic [DIG_W-1:0]     step_dig;

  // Unsigned negation of the most negative value wraps back onto 2^(WIDTH-1), the correct magnitude.
  always_comb begin
    in_neg = (SIGNED != 0) && in_data[WIDTH-1];
    in_mag = in_neg ? (-in_data) : in_data;
  end

  always_comb begin
    step_acc = acc_q;
    step_mag = mag_q;
    for (int s = 0; s < BITS_PER_CYCLE; s++) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (step_acc[4*d +: 4] >= 4'd5) begin
          step_acc[4*d +: 4] = step_acc[4*d +: 4] + 4'd3;
        end
      end
      step_acc = {step_acc[OUT_WIDTH-2:0], step_mag[PAD_W-1]};
      step_mag = {step_mag[PAD_W-2:0], 1'b0};
    end
  end

  always_comb begin
    step_dig = DIG_W'(1);
    for (int d = 1; d < DIGITS; d++) begin
      if (step_acc[4*d +: 4] != 4'd0) begin
        step_dig = DIG_W'(d + 1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    res_bcd_d = res_bcd_q;
    res_neg_d = res_neg_q;
    res_dig_d = res_dig_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mag_d   = PAD_W'(in_mag);
          acc_d   = '0;
          cnt_d   = CNT_W'(ITERS);
          neg_d   = in_neg;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        mag_d = step_mag;
        acc_d = step_acc;
        cnt_d = cnt_q - CNT_W'(1);
        // The final step's result goes straight into the held output registers.
        if (cnt_q == CNT_W'(1)) begin
          res_bcd_d = step_acc;
          res_neg_d = neg_q;
          res_dig_d = step_dig;
          state_d   = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      res_bcd_q <= '0;
      res_neg_q <= 1'b0;
      res_dig_q <= DIG_W'(1);
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      res_bcd_q <= res_bcd_d;
      res_neg_q <= res_neg_d;
      res_dig_q <= res_dig_d;
    end
  end

  assign out_bcd      = res_bcd_q;
  assign out_negative = res_neg_q;
  assign out_digits   = res_dig_q;

endmodule
